// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer and its input loader:
// section sizing helpers and the loader state encoding.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_IMG = 2'd1,
    LOAD_FLT = 2'd2,
    DONE     = 2'd3
  } state_e;

  function automatic int img_words(input int d, input int h, input int w);
    return d * h * w;
  endfunction

  function automatic int flt_words(input int k, input int d, input int f);
    return k * d * f * f;
  endfunction

  // Valid-convolution output size, one plane per kernel.
  function automatic int out_words(input int k, input int h, input int w, input int f);
    return k * (h - f + 1) * (w - f + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for n words; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_input_loader.sv
// Deserializes a valid/ready word stream into the flat image and filter
// buses of the convolution layer, holding the layer in reset until a full
// frame has been loaded.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame loaded, or last load aborted on early in_last
// LOAD_IMG | accepting image words, depth/row/column order
// LOAD_FLT | accepting filter words, kernel-major
// DONE     | frame complete, buses stable, conv layer released
module conv_input_loader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int K          = 6,
  localparam int IMG_WORDS = img_words(D, H, W),
  localparam int FLT_WORDS = flt_words(K, D, F),
  localparam int CNT_W     = cnt_width(max_int(IMG_WORDS, FLT_WORDS))
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              filt_only,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic [0:IMG_WORDS*DATA_WIDTH-1]   image,
  output logic [0:FLT_WORDS*DATA_WIDTH-1]   filters,
  output logic                              conv_reset,
  output logic                              load_done,
  output logic                              err
);

  localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_WORDS - 1);
  localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(FLT_WORDS - 1);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                idx_q, idx_d;
  logic [0:IMG_WORDS*DATA_WIDTH-1] image_q, image_d;
  logic [0:FLT_WORDS*DATA_WIDTH-1] filters_q, filters_d;
  logic                            err_q, err_d;
  logic                            done_q, done_d;
  logic                            crst_q, crst_d;

  logic xfer;
  logic img_last;
  logic flt_last;

  assign in_ready = (state_q == LOAD_IMG) || (state_q == LOAD_FLT);
  assign xfer     = in_valid && in_ready;
  assign img_last = (idx_q == IMG_LAST);
  assign flt_last = (idx_q == FLT_LAST);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start only honoured while not loading; in_last ends a
  // load early unless it lands on the final filter word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = filt_only ? LOAD_FLT : LOAD_IMG;
      end
      LOAD_IMG: begin
        if (xfer) begin
          if (in_last)       state_d = IDLE;
          else if (img_last) state_d = LOAD_FLT;
        end
      end
      LOAD_FLT: begin
        if (xfer) begin
          if (flt_last)     state_d = DONE;
          else if (in_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status next values: word placement, index, flags.
  always_comb begin
    idx_d     = idx_q;
    image_d   = image_q;
    filters_d = filters_q;
    err_d     = err_q;
    done_d    = done_q;
    crst_d    = crst_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d  = '0;
          err_d  = 1'b0;
          done_d = 1'b0;
          crst_d = 1'b1;
        end
      end
      LOAD_IMG: begin
        if (xfer) begin
          image_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
          if (in_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else if (img_last) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      LOAD_FLT: begin
        if (xfer) begin
          filters_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
          if (flt_last) begin
            // Frame completes even when in_last is missing; that is only flagged.
            idx_d  = '0;
            done_d = 1'b1;
            crst_d = 1'b0;
            if (!in_last) err_d = 1'b1;
          end else if (in_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  // Datapath and status registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q     <= '0;
      image_q   <= '0;
      filters_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      crst_q    <= 1'b1;
    end else begin
      idx_q     <= idx_d;
      image_q   <= image_d;
      filters_q <= filters_d;
      err_q     <= err_d;
      done_q    <= done_d;
      crst_q    <= crst_d;
    end
  end

  assign image      = image_q;
  assign filters    = filters_q;
  assign err        = err_q;
  assign load_done  = done_q;
  assign conv_reset = crst_q;

endmodule
